apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter APB_ADDR_WIDTH SHALL default to 32 and set the address width.
REQ-002 Parameter APB_DATA_WIDTH SHALL default to 32 and set the data width.
REQ-003 Parameter TIMEOUT_CYCLES SHALL default to 255 and set the maximum ACCESS wait cycles, range 0..65535, where 0 disables the timeout.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 pclk_i  in  1  clock; all state changes on the rising edge.
REQ-006 presetn_i  in  1  asynchronous active-low reset.
REQ-007 req_valid_i  in  1  request present.
REQ-008 req_ready_o  out  1  request accepted when req_valid_i and req_ready_o are both high on a clock edge.
REQ-009 req_addr_i  in  APB_ADDR_WIDTH  request byte address.
REQ-010 req_wdata_i  in  APB_DATA_WIDTH  write data.
REQ-011 req_write_i  in  1  1 for write, 0 for read.
REQ-012 rsp_valid_o  out  1  one-cycle response pulse.
REQ-013 rsp_rdata_o  out  APB_DATA_WIDTH  read data.
REQ-014 rsp_err_o  out  1  pslverr_i or timeout.
REQ-015 rsp_timeout_o  out  1  transfer aborted by timeout.
REQ-016 APB ports SHALL be: paddr_o out APB_ADDR_WIDTH; pwdata_o out APB_DATA_WIDTH; pwrite_o out 1; psel_o out 1; penable_o out 1; prdata_i in APB_DATA_WIDTH; pready_i in 1; pslverr_i in 1.

Function
REQ-017 The FSM SHALL have states IDLE, SETUP and ACCESS; req_ready_o SHALL be high only in IDLE.
REQ-018 On acceptance in IDLE, the block SHALL register addr, wdata and write into paddr_o, pwdata_o and pwrite_o, then move to SETUP.
REQ-019 In SETUP the outputs SHALL be psel_o=1 and penable_o=0, for exactly one cycle, followed by ACCESS.
REQ-020 In ACCESS the outputs SHALL be psel_o=1 and penable_o=1, with paddr_o, pwdata_o and pwrite_o stable until exit.
REQ-021 When ACCESS samples pready_i=1, the next cycle SHALL show: state IDLE, psel_o=0, penable_o=0, rsp_valid_o=1, rsp_err_o=pslverr_i, rsp_timeout_o=0.
REQ-022 On that completion, rsp_rdata_o SHALL equal the sampled prdata_i for reads and 0 for writes.
REQ-023 Latency SHALL be: accept at cycle N, SETUP at N+1, ACCESS at N+2; with zero waits, rsp_valid_o=1 and req_ready_o=1 at N+3, so one transfer takes 3 cycles and back-to-back transfers are allowed.
REQ-024 A 16-bit wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with pready_i=0.
REQ-025 If TIMEOUT_CYCLES>0 and the counter equals TIMEOUT_CYCLES while pready_i=0, the block SHALL exit to IDLE with rsp_valid_o=1, rsp_err_o=1, rsp_timeout_o=1 and rsp_rdata_o=0.
REQ-026 If pready_i=1 in the same cycle the timeout is reached, pready_i SHALL win and no timeout SHALL be flagged.
REQ-027 rsp_valid_o SHALL be a single-cycle pulse without backpressure; rsp_rdata_o, rsp_err_o and rsp_timeout_o SHALL hold until the next response.
REQ-028 In IDLE, paddr_o, pwdata_o and pwrite_o SHALL hold their last values; pslverr_i and prdata_i SHALL be ignored outside ACCESS.
REQ-029 Request inputs SHALL be ignored while req_ready_o=0.

Reset
REQ-030 Asserting presetn_i low SHALL immediately force state IDLE and psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o and rsp_timeout_o to 0.
REQ-031 Asserting presetn_i low SHALL immediately force paddr_o, pwdata_o, rsp_rdata_o and the wait counter to 0.
REQ-032 While presetn_i is low, req_ready_o SHALL be 0; from the first edge after release, req_ready_o SHALL be 1.
REQ-033 A reset during SETUP or ACCESS SHALL abort the transfer without producing a response.

Verification
REQ-034 Zero-wait write: addr 0x1000_0004, data 0xDEAD_BEEF, pready_i tied 1 -> SETUP then ACCESS with psel_o/penable_o pattern 10 then 11, rsp_valid_o at N+3 with rsp_err_o=0 and rsp_rdata_o=0.
REQ-035 Read with 3 waits: pready_i=0 for 3 ACCESS cycles, then 1 with prdata_i=0x1234_5678 -> rsp_valid_o at N+6, rsp_rdata_o=0x1234_5678, address stable throughout.
REQ-036 Slave error on read: pslverr_i=1 with pready_i=1 -> rsp_err_o=1, rsp_timeout_o=0.
REQ-037 Timeout with TIMEOUT_CYCLES=4: pready_i held 0 -> rsp_valid_o with rsp_err_o=1 and rsp_timeout_o=1 after 4 wait cycles; the same test with pready_i=1 on the 4th wait cycle -> normal completion.
REQ-038 Back-to-back: req_valid_i held high for 3 requests with zero waits -> accepts at cycles 0, 3 and 6, three rsp_valid_o pulses, no psel_o gap beyond one cycle.
REQ-039 Reset mid-ACCESS: presetn_i low during a wait state -> psel_o=0 asynchronously, no rsp_valid_o, req_ready_o=1 after release.

Source files
------------

// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB master bridging a valid/ready request port to a single APB transfer
// Three-state IDLE/SETUP/ACCESS sequencer with an optional ACCESS wait timeout.
module apb_master #(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      pclk_i,
   input  logic                      presetn_i,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
   input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
   input  logic                      req_write_i,
   output logic                      rsp_valid_o,
   output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic                      rsp_timeout_o,
   output logic [APB_ADDR_WIDTH-1:0] paddr_o,
   output logic [APB_DATA_WIDTH-1:0] pwdata_o,
   output logic                      pwrite_o,
   output logic                      psel_o,
   output logic                      penable_o,
   input  logic [APB_DATA_WIDTH-1:0] prdata_i,
   input  logic                      pready_i,
   input  logic                      pslverr_i
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

   state_e                      state_q, state_d;
   logic [APB_ADDR_WIDTH-1:0]   paddr_q, paddr_d;
   logic [APB_DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
   logic                        pwrite_q, pwrite_d;
   logic [15:0]                 wait_q, wait_d;
   logic                        rsp_valid_q, rsp_valid_d;
   logic [APB_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                        rsp_err_q, rsp_err_d;
   logic                        rsp_timeout_q, rsp_timeout_d;
   logic                        out_of_reset_q;
   logic                        timeout_hit;

   // Keeps req_ready_o low while reset is held, even though the state is already IDLE.
   always_ff @(posedge pclk_i or negedge presetn_i) begin
      if (!presetn_i) out_of_reset_q <= 1'b0;
      else            out_of_reset_q <= 1'b1;
   end

   always_ff @(posedge pclk_i or negedge presetn_i) begin
      if (!presetn_i) begin
         state_q       <= IDLE;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         pwrite_q      <= 1'b0;
         wait_q        <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         pwrite_q      <= pwrite_d;
         wait_q        <= wait_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign req_ready_o = (state_q == IDLE) && out_of_reset_q;
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_q == TIMEOUT_LIMIT);

   always_comb begin
      state_d       = state_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      pwrite_d      = pwrite_q;
      wait_d        = wait_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      case (state_q)
         IDLE: begin
            if (req_valid_i && req_ready_o) begin
               paddr_d  = req_addr_i;
               pwdata_d = req_wdata_i;
               pwrite_d = req_write_i;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            wait_d  = '0;
            state_d = ACCESS;
         end
         ACCESS: begin
            // A ready slave wins over a timeout reached in the same cycle.
            if (pready_i) begin
               state_d       = IDLE;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = pslverr_i;
               rsp_timeout_d = 1'b0;
               rsp_rdata_d   = pwrite_q ? '0 : prdata_i;
            end else if (timeout_hit) begin
               state_d       = IDLE;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_rdata_d   = '0;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign psel_o        = (state_q != IDLE);
   assign penable_o     = (state_q == ACCESS);
   assign paddr_o       = paddr_q;
   assign pwdata_o      = pwdata_q;
   assign pwrite_o      = pwrite_q;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_rdata_o   = rsp_rdata_q;
   assign rsp_err_o     = rsp_err_q;
   assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - scoreboard bench for apb_master with a scripted APB slave
module tb_apb_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        req_write = 1'b0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic        pwrite;
   logic        psel;
   logic        penable;
   logic [31:0] prdata = '0;
   logic        pready = 1'b1;
   logic        pslverr = 1'b0;

   apb_master #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
      .pclk_i(clk), .presetn_i(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .req_write_i(req_write),
      .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
      .rsp_timeout_o(rsp_timeout),
      .paddr_o(paddr), .pwdata_o(pwdata), .pwrite_o(pwrite), .psel_o(psel),
      .penable_o(penable), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        tmo;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   acc_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   int          s_waits = 0;
   logic        s_hang = 1'b0;
   logic        s_err = 1'b0;
   logic [31:0] s_rdata = '0;
   int          s_cnt = 0;

   logic [31:0] cur_addr = '0;
   logic [31:0] cur_wdata = '0;
   logic        cur_write = 1'b0;
   logic        psel_prev = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n && req_valid && req_ready) begin
         acc_q.push_back(cyc);
         cur_addr  <= req_addr;
         cur_wdata <= req_wdata;
         cur_write <= req_write;
      end
   end

   // Slave model: wait states, then the scripted response; garbage outside ACCESS.
   always @(negedge clk) begin
      if (psel && penable) begin
         pready  = !s_hang && (s_cnt == s_waits);
         pslverr = pready ? s_err : 1'b1;
         prdata  = pready ? s_rdata : 32'hBAD0_BAD0;
         s_cnt++;
      end else begin
         pready  = 1'b1;
         pslverr = 1'b1;
         prdata  = 32'hBAD1_BAD1;
         s_cnt   = 0;
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         psel_prev = 1'b0;
      end else begin
         if (rsp_valid) begin
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
            end else begin
               exp_t e;
               int   a;
               e = exp_q.pop_front();
               a = acc_q.pop_front();
               chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
               chk("rsp_err", 64'(rsp_err), 64'(e.err));
               chk("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
               chk("rsp_latency", 64'(cyc - a), 64'(e.lat));
            end
         end
         if (psel) begin
            chk("penable_phase", 64'(penable), 64'(psel_prev));
            chk("paddr_stable", 64'(paddr), 64'(cur_addr));
            chk("pwdata_stable", 64'(pwdata), 64'(cur_wdata));
            chk("pwrite_stable", 64'(pwrite), 64'(cur_write));
         end else begin
            chk("penable_idle", 64'(penable), 64'd0);
         end
         psel_prev = psel;
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input logic [31:0] e_rdata, input logic e_err, input logic e_tmo,
                       input int e_lat);
      int n;
      exp_q.push_back('{rdata: e_rdata, err: e_err, tmo: e_tmo, lat: e_lat});
      req_valid = 1'b1;
      req_addr  = a;
      req_wdata = d;
      req_write = w;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got req_ready=0 for 50 cycles expected 1");
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
         exp_q.delete();
         acc_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic slave(input int waits, input logic hang, input logic err, input logic [31:0] rd);
      s_waits = waits;
      s_hang  = hang;
      s_err   = err;
      s_rdata = rd;
   endtask

   initial begin
      @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_psel", 64'(psel), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_paddr", 64'(paddr), 64'd0);
      chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_req_ready", 64'(req_ready), 64'd1);

      slave(0, 1'b0, 1'b0, 32'h0);
      send(32'h1000_0004, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, 1'b0, 3);
      req_valid = 1'b0;
      drain();

      slave(3, 1'b0, 1'b0, 32'h1234_5678);
      send(32'h2000_0010, 32'h0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 6);
      req_valid = 1'b0;
      drain();

      slave(0, 1'b0, 1'b1, 32'hCAFE_0001);
      send(32'h3000_0000, 32'h0, 1'b0, 32'hCAFE_0001, 1'b1, 1'b0, 3);
      req_valid = 1'b0;
      drain();

      slave(0, 1'b1, 1'b0, 32'h0);
      send(32'h4000_0008, 32'h5555_AAAA, 1'b1, 32'h0, 1'b1, 1'b1, 7);
      req_valid = 1'b0;
      drain();

      slave(4, 1'b0, 1'b0, 32'hA5A5_5A5A);
      send(32'h4000_000C, 32'h0, 1'b0, 32'hA5A5_5A5A, 1'b0, 1'b0, 7);
      req_valid = 1'b0;
      drain();

      slave(1, 1'b0, 1'b1, 32'hFFFF_FFFF);
      send(32'h5000_0000, 32'h0123_4567, 1'b1, 32'h0, 1'b1, 1'b0, 4);
      req_valid = 1'b0;
      drain();

      slave(0, 1'b0, 1'b0, 32'h8765_4321);
      send(32'h6000_0000, 32'h1111_1111, 1'b1, 32'h0, 1'b0, 1'b0, 3);
      send(32'h6000_0004, 32'h0, 1'b0, 32'h8765_4321, 1'b0, 1'b0, 3);
      send(32'h6000_0008, 32'h3333_3333, 1'b1, 32'h0, 1'b0, 1'b0, 3);
      req_valid = 1'b0;
      drain();

      slave(0, 1'b1, 1'b0, 32'h0);
      exp_q.push_back('{rdata: 32'h0, err: 1'b0, tmo: 1'b0, lat: 0});
      req_valid = 1'b1;
      req_addr  = 32'h7000_0000;
      req_write = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_rst_in_access", 64'(penable), 64'd1);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      acc_q.delete();
      #1;
      chk("async_rst_psel", 64'(psel), 64'd0);
      chk("async_rst_penable", 64'(penable), 64'd0);
      chk("async_rst_req_ready", 64'(req_ready), 64'd0);
      chk("async_rst_paddr", 64'(paddr), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_release_req_ready", 64'(req_ready), 64'd1);
      repeat (3) @(negedge clk);

      slave(2, 1'b0, 1'b0, 32'h0);
      send(32'h0000_0100, 32'h0BAD_F00D, 1'b1, 32'h0, 1'b0, 1'b0, 5);
      req_valid = 1'b0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench timeout");
   end

endmodule
